// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam int M_W    = 4;
  localparam int SS_W   = 6;
  localparam int D_W    = 4;

  localparam int M_MAX  = 9;
  localparam int SS_MAX = 59;
  localparam int D_MAX  = 9;

  // One displayed time value, minutes in the top bits.
  typedef struct packed {
    logic [M_W-1:0]  m;
    logic [SS_W-1:0] ss;
    logic [D_W-1:0]  d;
  } sw_time_t;

  // True when the datapath shows 9:59.9 and must not advance further.
  function automatic logic is_max(input sw_time_t t);
    return (t.m == M_W'(M_MAX)) && (t.ss == SS_W'(SS_MAX)) && (t.d == D_W'(D_MAX));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge press pulse.
// Latency: press pulse 2 + DEB_CYCLES cycles after the raw edge.
// Backpressure: none; one registered single-cycle pulse per accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          lvl;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive differing samples; pulse on rising acceptance.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else if (sync2 == lvl) begin
      cnt   <= '0;
      press <= 1'b0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      lvl   <= sync2;
      cnt   <= '0;
      press <= sync2;
    end else begin
      cnt   <= cnt + CW'(1);
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, decisecond prescaler, run/lap/stop FSM, display mux.
// Latency: state changes one cycle after a press event; cnt_en/cnt_clr are registered pulses.
// Backpressure: none; the datapath must act on every cnt_en/cnt_clr pulse it sees.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            btn_ss,
  input  logic            btn_lr,
  input  logic [M_W-1:0]  live_m,
  input  logic [SS_W-1:0] live_ss,
  input  logic [D_W-1:0]  live_d,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic [M_W-1:0]  disp_m,
  output logic [SS_W-1:0] disp_ss,
  output logic [D_W-1:0]  disp_d,
  output logic            running,
  output logic            ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sw_state_t     state;
  sw_state_t     state_nx;
  sw_time_t      live;
  sw_time_t      lap;
  logic [PW-1:0] presc;
  logic          ev_ss;
  logic          ev_lr;
  logic          counting;
  logic          tick;
  logic          sat;
  logic          do_clr;
  logic          do_cap;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (btn_ss),
    .press (ev_ss)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (btn_lr),
    .press (ev_lr)
  );

  assign live     = {live_m, live_ss, live_d};
  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PW'(TICK_DIV - 1));
  // The would-be advance past 9:59.9 is swallowed and turned into a stop.
  assign sat      = tick && is_max(live);
  assign running  = counting;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus clear/capture strobes; start/stop has priority over lap/reset, saturation over both.
  always_comb begin
    state_nx = state;
    do_clr   = 1'b0;
    do_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (ev_ss) begin
          state_nx = RUN;
        end else if (ev_lr) begin
          do_clr = 1'b1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          state_nx = STOP;
        end else if (ev_lr) begin
          state_nx = LAP;
          do_cap   = 1'b1;
        end
      end
      LAP: begin
        if (ev_ss) begin
          state_nx = STOP;
        end else if (ev_lr) begin
          state_nx = RUN;
        end
      end
      STOP: begin
        if (ev_ss) begin
          state_nx = RUN;
        end else if (ev_lr) begin
          state_nx = IDLE;
          do_clr   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (sat) begin
      state_nx = STOP;
      do_cap   = 1'b0;
    end
  end

  // Prescaler runs only while counting and holds while paused so no partial decisecond is lost.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc <= '0;
    end else if (do_clr) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Registered datapath strobes and the sticky overflow flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cnt_en  <= tick && !sat;
      cnt_clr <= do_clr;
      if (sat) begin
        ovf <= 1'b1;
      end else if (do_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Lap register samples the live count on the edge that enters LAP.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lap <= '0;
    end else if (do_cap) begin
      lap <= live;
    end
  end

  assign {disp_m, disp_ss, disp_d} = (state == LAP) ? lap : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [3:0] live_m = 4'd0;
  logic [5:0] live_ss = 6'd0;
  logic [3:0] live_d = 4'd0;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] disp_m;
  logic [5:0] disp_ss;
  logic [3:0] disp_d;
  logic       running;
  logic       ovf;

  logic       dp_clr = 1'b0;
  logic       dp_load = 1'b0;
  logic [3:0] ld_m = 4'd0;
  logic [5:0] ld_ss = 6'd0;
  logic [3:0] ld_d = 4'd0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pulses;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .live_m  (live_m),
    .live_ss (live_ss),
    .live_d  (live_d),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .disp_m  (disp_m),
    .disp_ss (disp_ss),
    .disp_d  (disp_d),
    .running (running),
    .ovf     (ovf)
  );

  // Behavioural stopwatch datapath feeding live_*.
  always @(posedge clk) begin
    if (dp_clr || cnt_clr) begin
      live_m  <= 4'd0;
      live_ss <= 6'd0;
      live_d  <= 4'd0;
    end else if (dp_load) begin
      live_m  <= ld_m;
      live_ss <= ld_ss;
      live_d  <= ld_d;
    end else if (cnt_en) begin
      if (live_d == 4'd9) begin
        live_d <= 4'd0;
        if (live_ss == 6'd59) begin
          live_ss <= 6'd0;
          live_m  <= live_m + 4'd1;
        end else begin
          live_ss <= live_ss + 6'd1;
        end
      end else begin
        live_d <= live_d + 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Display as m*1000 + ss*10 + d, e.g. 9:59.9 -> 9599.
  function automatic int disp_val();
    return int'(disp_m) * 1000 + int'(disp_ss) * 10 + int'(disp_d);
  endfunction

  task automatic do_reset();
    clr_n  = 1'b0;
    dp_clr = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    tick(2);
    dp_clr = 1'b0;
    clr_n  = 1'b1;
    tick(1);
  endtask

  initial begin
    // ---- reset state, start latency, tick period, count after 40 cycles
    do_reset();
    chk("rst_running", int'(running), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_disp", disp_val(), 0);
    btn_ss = 1'b1;
    tick(5);
    chk("start_n5_running", int'(running), 0);
    tick(1);
    chk("start_n6_running", int'(running), 1);
    btn_ss = 1'b0;
    tick(3);
    chk("first_en_n9", int'(cnt_en), 0);
    tick(1);
    chk("first_en_n10", int'(cnt_en), 1);
    tick(1);
    chk("en_width_n11", int'(cnt_en), 0);
    tick(3);
    chk("en_period_n14", int'(cnt_en), 1);
    tick(32);
    chk("run40_pre", disp_val(), 9);
    tick(1);
    chk("run40_1s", disp_val(), 10);

    // ---- glitch rejection, then a 3-cycle press
    do_reset();
    btn_ss = 1'b1;
    tick(2);
    btn_ss = 1'b0;
    tick(10);
    chk("glitch_idle", int'(running), 0);
    btn_ss = 1'b1;
    tick(3);
    btn_ss = 1'b0;
    tick(3);
    chk("press3_run", int'(running), 1);

    // ---- lap freeze at 0:00.7, release on second lr
    do_reset();
    btn_ss = 1'b1;
    tick(6);
    btn_ss = 1'b0;
    tick(25);
    btn_lr = 1'b1;
    tick(6);
    chk("lap_running", int'(running), 1);
    chk("lap_capture", disp_val(), 7);
    btn_lr = 1'b0;
    tick(10);
    chk("lap_frozen", disp_val(), 7);
    btn_lr = 1'b1;
    tick(6);
    chk("lap_release", disp_val(), 11);
    chk("lap_release_run", int'(running), 1);
    btn_lr = 1'b0;

    // ---- pause keeps prescaler phase; reset from STOP clears it
    do_reset();
    btn_ss = 1'b1;
    tick(6);
    btn_ss = 1'b0;
    tick(5);
    btn_ss = 1'b1;
    tick(6);
    chk("pause_stop", int'(running), 0);
    btn_ss = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (cnt_en) pulses++;
    end
    chk("pause_no_en", pulses, 0);
    chk("pause_hold", disp_val(), 2);
    btn_ss = 1'b1;
    tick(6);
    chk("resume_run", int'(running), 1);
    chk("resume_en_n0", int'(cnt_en), 0);
    tick(1);
    chk("resume_en_n1", int'(cnt_en), 1);
    btn_ss = 1'b0;
    tick(10);
    btn_ss = 1'b1;
    tick(6);
    chk("stop2", int'(running), 0);
    btn_ss = 1'b0;
    tick(8);
    btn_lr = 1'b1;
    tick(6);
    chk("clr_pulse", int'(cnt_clr), 1);
    chk("clr_idle", int'(running), 0);
    btn_lr = 1'b0;
    tick(1);
    chk("clr_width", int'(cnt_clr), 0);
    chk("clr_live0", disp_val(), 0);
    btn_ss = 1'b1;
    tick(6);
    chk("restart_run", int'(running), 1);
    btn_ss = 1'b0;
    tick(3);
    chk("restart_en_n3", int'(cnt_en), 0);
    tick(1);
    chk("restart_en_n4", int'(cnt_en), 1);

    // ---- simultaneous ss+lr from RUN -> STOP
    do_reset();
    btn_ss = 1'b1;
    tick(6);
    btn_ss = 1'b0;
    tick(8);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    tick(6);
    chk("both_stop", int'(running), 0);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    tick(8);
    btn_lr = 1'b1;
    tick(6);
    chk("both_then_lr_clr", int'(cnt_clr), 1);
    chk("both_then_lr_idle", int'(running), 0);
    btn_lr = 1'b0;

    // ---- full run to saturation
    do_reset();
    btn_ss = 1'b1;
    tick(6);
    btn_ss = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30000; i++) begin
      tick(1);
      if (cnt_en) pulses++;
      if (ovf) break;
    end
    chk("sat_ovf", int'(ovf), 1);
    chk("sat_pulses", pulses, 5999);
    chk("sat_stop", int'(running), 0);
    chk("sat_disp", disp_val(), 9599);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (cnt_en) pulses++;
    end
    chk("sat_no_more_en", pulses, 0);
    chk("sat_hold", disp_val(), 9599);
    btn_lr = 1'b1;
    tick(6);
    chk("sat_lr_ovf", int'(ovf), 0);
    chk("sat_lr_idle", int'(running), 0);
    chk("sat_lr_clr", int'(cnt_clr), 1);
    btn_lr = 1'b0;
    tick(1);
    chk("sat_lr_live0", disp_val(), 0);

    // ---- short saturation from a preloaded 9:59.8, then reset mid-run
    ld_m    = 4'd9;
    ld_ss   = 6'd59;
    ld_d    = 4'd8;
    dp_load = 1'b1;
    tick(1);
    dp_load = 1'b0;
    tick(6);
    btn_ss = 1'b1;
    tick(6);
    btn_ss = 1'b0;
    tick(7);
    chk("sat2_pre_ovf", int'(ovf), 0);
    tick(1);
    chk("sat2_ovf", int'(ovf), 1);
    chk("sat2_en", int'(cnt_en), 0);
    chk("sat2_stop", int'(running), 0);
    tick(6);
    btn_ss = 1'b1;
    tick(6);
    chk("sat2_rerun", int'(running), 1);
    chk("sat2_ovf_sticky", int'(ovf), 1);
    btn_ss = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("midrst_running", int'(running), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_cnt_en", int'(cnt_en), 0);
    chk("midrst_cnt_clr", int'(cnt_clr), 0);
    chk("midrst_disp_live", disp_val(), 9599);
    tick(2);
    clr_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven control unit for the stopwatch datapath (M minutes 0–9, SS seconds 0–59, D deciseconds 0–9). It performs the following:
- debounces two push-buttons;
- divides the system clock into decisecond count-enable pulses;
- sequences run/pause/lap/reset through an FSM;
- muxes the live count or a captured lap value onto the display outputs.

It sits between the board buttons and the stopwatch datapath. The datapath advances one decisecond per `cnt_en` pulse and zeroes on `cnt_clr`.

## Interface
Parameters:
- `TICK_DIV`, 10_000_000 — clk cycles per decisecond (≥2)
- `DEB_CYCLES`, 500_000 — cycles a synchronized button level must be stable before it is accepted (≥1)

Ports:
- `clk`  in  1  system clock
- `clr_n`  in  1  reset; one clock; asynchronous, active-low
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous
- `btn_lr`  in  1  raw lap/reset button, active-high, asynchronous
- `live_m`  in  4  datapath minutes
- `live_ss`  in  6  datapath seconds
- `live_d`  in  4  datapath deciseconds
- `cnt_en`  out  1  one-cycle datapath advance pulse
- `cnt_clr`  out  1  one-cycle datapath clear pulse
- `disp_m`  out  4  displayed minutes
- `disp_ss`  out  6  displayed seconds
- `disp_d`  out  4  displayed deciseconds
- `running`  out  1  high in RUN and LAP
- `ovf`  out  1  sticky, set when the count saturates at 9:59.9

## Operation
Buttons:
- Each button passes through a 2-FF synchronizer, then a stability counter.
- The debounced level updates only after `DEB_CYCLES` consecutive equal samples.
- A press event is a single-cycle pulse on the debounced rising edge. Releases generate nothing.

Prescaler:
- Counts 0..`TICK_DIV`-1, advancing only in RUN and LAP.
- Holds its value in IDLE and STOP, so pausing loses no sub-decisecond time.
- Cleared whenever `cnt_clr` is issued.
- `cnt_en` = prescaler == `TICK_DIV`-1 while counting.

FSM states: IDLE, RUN, LAP, STOP.
- IDLE + ss → RUN. IDLE + lr → IDLE, with a `cnt_clr` pulse.
- RUN + ss → STOP. RUN + lr → LAP; capture the live_* values into the lap register.
- LAP + ss → STOP; lap freeze released. LAP + lr → RUN; lap freeze released.
- STOP + ss → RUN. STOP + lr → IDLE, with a `cnt_clr` pulse; `ovf` is cleared.
- Simultaneous ss and lr events: ss wins and lr is discarded.

Display mux:
- LAP: disp_* = lap register.
- All other states: disp_* = live_*.

Saturation:
- Applies when live = 9:59.9 and a `cnt_en` would fire in RUN or LAP.
- That pulse is suppressed, `ovf` is set, and the FSM moves to STOP.
- The datapath never wraps under this controller.

## Timing
- Reset (`clr_n` low): state IDLE; `cnt_en`=0, `cnt_clr`=0, `running`=0, `ovf`=0; lap register, prescaler, synchronizers and debounce counters all zero; disp_* follow live_* combinationally.
- Button latency: an edge on `btn_*` becomes a press event 2 (sync) + `DEB_CYCLES` cycles later. The state and `running` update on the following edge.
- `cnt_clr`: registered, asserted in the cycle after the lr event, exactly 1 cycle wide. The prescaler reads 0 in that same cycle.
- `cnt_en`: registered, 1 cycle wide, period exactly `TICK_DIV` cycles while counting. The first pulse after RUN entry from IDLE arrives `TICK_DIV` cycles after entry.
- Lap capture: samples live_* on the same edge that enters LAP.
- disp_* are combinational from the state and the lap register.
- Reset mid-operation: immediate return to the reset values, with no `cnt_clr` pulse. The datapath is reset separately.

## Structure
- `stopwatch_pkg`:
  - state enum: IDLE, RUN, LAP, STOP;
  - width constants: `M_W`=4, `SS_W`=6, `D_W`=4;
  - maximum-value constants: `M_MAX`=9, `SS_MAX`=59, `D_MAX`=9.
- Sub-module `btn_debounce`: synchronizer, stability counter and rising-edge pulse, parameterized by `DEB_CYCLES`. Instantiated twice.
- Prescaler, FSM, lap register and display mux live in the top module.

## Test plan
All scenarios use `TICK_DIV`=4, `DEB_CYCLES`=3, with a behavioural stopwatch model driving live_*.
- Reset then ss press → `running`=1 after 2+3+1 cycles; `cnt_en` pulses every 4 cycles; after 40 cycles of RUN, live = 0:01.0.
- A 2-cycle glitch on `btn_ss` → no press event and the state stays IDLE. A 3-cycle-stable press → RUN.
- RUN at 0:00.7, lr press → LAP with disp frozen at 0:00.7 while live keeps counting. A second lr → disp tracks live again.
- RUN, ss at prescaler=2 → STOP. ss again → RUN, and the next `cnt_en` arrives 1 cycle later. STOP + lr → exactly one `cnt_clr` cycle, IDLE, live 0:00.0.
- ss and lr events in the same cycle from RUN → STOP, with no lap capture.
- Run to 9:59.9 → no further `cnt_en`, `ovf`=1, STOP, live holds 9:59.9. lr → `ovf`=0, IDLE. Asserting `clr_n` mid-run → all outputs at their reset values.
